gcd_engine: RTL and testbench

//  Iterative 32-bit greatest-common-divisor engine using Euclid's modulo algorithm.
//  A start pulse captures operands p and q; a sequential remainder unit runs until the remainder is zero.
//  The result is presented on gcd and held until the next completion. Standalone arithmetic block, single clock domain.

---
 rtl/gcd_pkg.sv | 37 +++
 rtl/mod_unit.sv | 77 +++++++
 rtl/gcd_engine.sv | 124 ++++++++++++
 tb/tb_gcd_engine.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
//==============================================================================
// Module   : gcd_pkg
// Purpose  : Shared width, FSM state type and restoring-division step for the
//            gcd_engine block.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package gcd_pkg;

  localparam int WIDTH  = 32;
  localparam int STEP_W = 6;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MOD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [WIDTH:0] mod_step(input logic [WIDTH:0]   part,
                                               input logic             next_bit,
                                               input logic [WIDTH-1:0] divisor);
    logic [WIDTH:0] shifted;
    shifted = (part << 1) | {{WIDTH{1'b0}}, next_bit};
    if (shifted >= {1'b0, divisor}) begin
      mod_step = shifted - {1'b0, divisor};
    end else begin
      mod_step = shifted;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_unit.sv
//==============================================================================
// Module   : mod_unit
// Purpose  : Restoring shift-subtract remainder unit; done pulses exactly
//            WIDTH cycles after load with rem = dividend % divisor.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mod_unit
  import gcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             done
);

  logic [WIDTH:0]    part_q, part_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  div_q, div_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // The first step is taken on the load edge so the last one lands in time
  // for done to be visible in the WIDTH-th cycle after load.
  always_comb begin
    part_d = part_q;
    quo_d  = quo_q;
    div_d  = div_q;
    step_d = step_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load) begin
      part_d = mod_step('0, dividend[WIDTH-1], divisor);
      quo_d  = dividend << 1;
      div_d  = divisor;
      step_d = STEP_W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      part_d = mod_step(part_q, quo_q[WIDTH-1], div_q);
      quo_d  = quo_q << 1;
      step_d = step_q + STEP_W'(1);
      if (step_q == LAST_STEP) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_q <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      part_q <= part_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      step_q <= step_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign rem  = part_q[WIDTH-1:0];
  assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/gcd_engine.sv
//==============================================================================
// Module   : gcd_engine
// Purpose  : Iterative Euclid GCD engine driving a sequential remainder unit.
//            Build macro GCD_STEP_COUNT_EN: y shows the iteration count instead
//            of the live remainder register b.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gcd_engine
  import gcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] gcd,
  output logic [WIDTH-1:0] y
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             start_q;
  logic             launch;
  logic             iter_done;
  logic             mod_load;
  logic             mod_done;
  logic [WIDTH-1:0] mod_rem;

  assign launch    = (state_q == IDLE) && start && !start_q;
  assign iter_done = (state_q == MOD) && mod_done;
  assign mod_load  = (state_q == CHECK) && (b_q != '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          a_d     = p;
          b_d     = q;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = DONE;
        end else begin
          state_d = MOD;
        end
      end
      MOD: begin
        if (iter_done) begin
          a_d     = b_q;
          b_d     = mod_rem;
          state_d = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      start_q <= start;
    end
  end

  mod_unit u_mod (
    .clk      (clk),
    .rst      (rst),
    .load     (mod_load),
    .dividend (a_q),
    .divisor  (b_q),
    .rem      (mod_rem),
    .done     (mod_done)
  );

`ifdef GCD_STEP_COUNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (launch) begin
      cnt_d = '0;
    end else if (iter_done) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign y = cnt_q;
`else
  assign y = b_q;
`endif

  assign gcd = gcd_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_engine.sv
//==============================================================================
// Module   : tb_gcd_engine
// Purpose  : Self-checking bench for gcd_engine against an Euclid reference.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] p, q, gcd, y;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_gcd = '0;
  logic [31:0] m_b[$];

  gcd_engine dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .q     (q),
    .gcd   (gcd),
    .y     (y)
  );

  always #5 clk = ~clk;

  // Plain Euclid: records b after every iteration and the final gcd.
  task automatic model(input logic [31:0] a0, input logic [31:0] b0,
                       output logic [31:0] g, output int n);
    logic [31:0] aa, bb, t;
    m_b.delete();
    aa = a0; bb = b0; n = 0;
    while (bb != 0) begin
      t  = aa % bb;
      aa = bb;
      bb = t;
      n++;
      m_b.push_back(bb);
    end
    g = aa;
  endtask

  // Launch one computation and check y per iteration plus gcd timing/value.
  task automatic do_compute(input logic [31:0] pv, input logic [31:0] qv,
                            input int hold, input bit poke, input string tag);
    logic [31:0] g, ey;
    int          n, last, k;
    model(pv, qv, g, n);
    last = 33 * n + 2;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    p = pv; q = qv; start = 1'b1;
    for (int e = 1; e <= last; e++) begin
      @(posedge clk); #1;
      if (e == hold) start = 1'b0;
      if (poke && e == 10) begin p = ~pv; q = qv + 32'd3; start = 1'b1; end
      if (poke && e == 11) start = 1'b0;
      if (e > 1 && (e - 1) % 33 == 0 && e < last) begin
        k = (e - 1) / 33;
`ifdef GCD_STEP_COUNT_EN
        ey = k;
`else
        ey = m_b[k-1];
`endif
        tests++;
        if (y !== ey) begin
          fails++;
          $display("FAIL %s y@iter%0d: got %h expected %h", tag, k, y, ey);
        end
      end
      if (e == last - 1) begin
        tests++;
        if (gcd !== model_gcd) begin
          fails++;
          $display("FAIL %s gcd_before_done: got %h expected %h", tag, gcd, model_gcd);
        end
      end
      if (e == last) begin
`ifdef GCD_STEP_COUNT_EN
        ey = n;
`else
        ey = 32'd0;
`endif
        tests += 2;
        if (gcd !== g) begin
          fails++;
          $display("FAIL %s gcd: got %h expected %h", tag, gcd, g);
        end
        if (y !== ey) begin
          fails++;
          $display("FAIL %s y_final: got %h expected %h", tag, y, ey);
        end
      end
    end
    model_gcd = g;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; p = '0; q = '0;
    repeat (3) @(posedge clk);
    #1;
    tests += 2;
    if (gcd !== 32'd0) begin fails++; $display("FAIL reset_gcd: got %h expected 0", gcd); end
    if (y !== 32'd0)   begin fails++; $display("FAIL reset_y: got %h expected 0", y); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (gcd !== 32'd0) begin fails++; $display("FAIL post_reset_gcd: got %h expected 0", gcd); end
  endtask

  task automatic test_vectors();
    do_compute(32'h568F, 32'h50A1, 2, 1'b0, "v568f");
    do_compute(32'h20, 32'h16, 1, 1'b0, "v20_16");
    do_compute(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0, "vmax");
  endtask

  task automatic test_zero_operands();
    do_compute(32'd7, 32'd0, 1, 1'b0, "q_zero");
    do_compute(32'd0, 32'd9, 1, 1'b0, "p_zero");
    do_compute(32'd0, 32'd0, 1, 1'b0, "both_zero");
  endtask

  task automatic test_swap_hold();
    logic [31:0] y_hold;
`ifdef GCD_STEP_COUNT_EN
    y_hold = 32'd3;
`else
    y_hold = 32'd0;
`endif
    do_compute(32'd12, 32'd18, 1 << 30, 1'b0, "swap");
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (c % 10 == 0) begin
        tests += 2;
        if (gcd !== 32'd6) begin fails++; $display("FAIL hold_gcd c%0d: got %h expected 6", c, gcd); end
        if (y !== y_hold)  begin fails++; $display("FAIL hold_y c%0d: got %h expected %h", c, y, y_hold); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_relaunch_ignored();
    do_compute(32'd1071, 32'd462, 1, 1'b1, "relaunch");
  endtask

  task automatic test_reset_mid();
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    p = 32'd1000; q = 32'd37; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests += 2;
    if (gcd !== 32'd0) begin fails++; $display("FAIL midrst_gcd: got %h expected 0", gcd); end
    if (y !== 32'd0)   begin fails++; $display("FAIL midrst_y: got %h expected 0", y); end
    @(negedge clk);
    rst = 1'b0;
    model_gcd = 32'd0;
    do_compute(32'd48, 32'd18, 1, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [31:0] pv, qv, f;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        pv = $urandom; qv = $urandom;
      end else if (i < 6) begin
        f  = $urandom_range(2, 500);
        pv = f * $urandom_range(1, 100000);
        qv = f * $urandom_range(1, 100000);
      end else begin
        pv = $urandom_range(0, 300);
        qv = $urandom_range(0, 300);
      end
      do_compute(pv, qv, 1, i[0], $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero_operands();
    test_swap_hold();
    test_relaunch_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
